// File: rtl/sync_fifo_param_pkg.sv
// Shared read-mode constants and sizing helpers for the parametrised synchronous FIFO.
// Imported by the FIFO top and its storage array.
package sync_fifo_param_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int addrWidth(input int depth);
        return $clog2(depth);
    endfunction

    // One extra MSB lets equal low bits be told apart as full or empty.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit isPow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// DEPTH x DATA_W storage with a synchronous write port and an asynchronous read port.
// The contents are deliberately not reset.
module fifo_ram_sp
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [addrWidth(DEPTH)-1:0]  waddr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [addrWidth(DEPTH)-1:0]  raddr_i,
    output logic [DATA_W-1:0]            rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost-full/empty thresholds and
// sticky overflow/underflow flags; supports registered-read and first-word-fall-through modes.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int AF_TH  = DEPTH - 2,
    parameter int AE_TH  = 2,
    parameter int FWFT   = FIFO_STD
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic [DATA_W-1:0]           data_in_i,
    input  logic                        rd_en_i,
    output logic [DATA_W-1:0]           data_out_o,
    output logic                        rd_valid_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        almost_full_o,
    output logic                        almost_empty_o,
    output logic [ptrWidth(DEPTH)-1:0]  count_o,
    output logic                        overflow_o,
    output logic                        underflow_o,
    input  logic                        clr_err_i
);

    localparam int AW = addrWidth(DEPTH);
    localparam int PW = ptrWidth(DEPTH);

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_TH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_TH);

    if (!isPow2(DEPTH) || AF_TH < 0 || AF_TH > DEPTH || AE_TH < 0 || AE_TH >= DEPTH) begin : gBadParams
        $error("sync_fifo_param: DEPTH must be a power of two >= 2, AF_TH <= DEPTH, AE_TH < DEPTH");
    end

    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [PW-1:0]     count_q, count_d;
    logic              full_q, empty_q, almostFull_q, almostEmpty_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wrAcc, rdAcc;
    logic [DATA_W-1:0] ramRdata;

    // Acceptance uses the flags registered at the start of the cycle, so a read never frees a slot for a same-cycle write.
    assign wrAcc = wr_en_i && !full_q;
    assign rdAcc = rd_en_i && !empty_q;

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wrAcc) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (rdAcc) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (wr_en_i && full_q) begin
            overflow_d = 1'b1;
        end else if (clr_err_i) begin
            overflow_d = 1'b0;
        end
        if (rd_en_i && empty_q) begin
            underflow_d = 1'b1;
        end else if (clr_err_i) begin
            underflow_d = 1'b0;
        end
        count_d = wrPtr_d - rdPtr_d;
    end

    // Flags are derived from the next fill level so they change on the same edge as count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almostFull_q  <= (AF_TH == 0);
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            full_q        <= (count_d == DEPTH_C);
            empty_q       <= (count_d == '0);
            almostFull_q  <= (count_d >= AF_C);
            almostEmpty_q <= (count_d <= AE_C);
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    fifo_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) uRam (
        .clk_i   (clk_i),
        .we_i    (wrAcc && !rst_i),
        .waddr_i (wrPtr_q[AW-1:0]),
        .wdata_i (data_in_i),
        .raddr_i (rdPtr_q[AW-1:0]),
        .rdata_o (ramRdata)
    );

    if (FWFT == FIFO_STD) begin : gStd
        logic [DATA_W-1:0] dataOut_q;
        logic              rdValid_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dataOut_q <= '0;
                rdValid_q <= 1'b0;
            end else begin
                rdValid_q <= rdAcc;
                if (rdAcc) begin
                    dataOut_q <= ramRdata;
                end
            end
        end

        assign data_out_o = dataOut_q;
        assign rd_valid_o = rdValid_q;
    end else begin : gFwft
        assign data_out_o = ramRdata;
        assign rd_valid_o = !empty_q;
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = almostFull_q;
    assign almost_empty_o = almostEmpty_q;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a DEPTH=32 registered-read instance and a
// DEPTH=4 first-word-fall-through instance, compared against hand-computed values.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errorCount = 0;
    int checkCount = 0;

    logic       sRst, sWr, sRd, sClr;
    logic [7:0] sDin, sDout;
    logic       sRv, sFull, sEmpty, sAf, sAe, sOvf, sUnf;
    logic [5:0] sCnt;

    logic       fRst, fWr, fRd, fClr;
    logic [7:0] fDin, fDout;
    logic       fRv, fFull, fEmpty, fAf, fAe, fOvf, fUnf;
    logic [2:0] fCnt;

    sync_fifo_param #(.DATA_W(8), .DEPTH(32), .FWFT(0)) dutStd (
        .clk_i(clk), .rst_i(sRst), .wr_en_i(sWr), .data_in_i(sDin), .rd_en_i(sRd),
        .data_out_o(sDout), .rd_valid_o(sRv), .full_o(sFull), .empty_o(sEmpty),
        .almost_full_o(sAf), .almost_empty_o(sAe), .count_o(sCnt),
        .overflow_o(sOvf), .underflow_o(sUnf), .clr_err_i(sClr)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(4), .FWFT(1)) dutFwft (
        .clk_i(clk), .rst_i(fRst), .wr_en_i(fWr), .data_in_i(fDin), .rd_en_i(fRd),
        .data_out_o(fDout), .rd_valid_o(fRv), .full_o(fFull), .empty_o(fEmpty),
        .almost_full_o(fAf), .almost_empty_o(fAe), .count_o(fCnt),
        .overflow_o(fOvf), .underflow_o(fUnf), .clr_err_i(fClr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change at the falling edge; returning at the next falling edge leaves outputs settled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
        sWr  = wr;
        sDin = din;
        sRd  = rd;
        sClr = clr;
        tick();
        sWr  = 1'b0;
        sRd  = 1'b0;
        sClr = 1'b0;
    endtask

    task automatic applyFwftStimulus(input logic wr, input logic [7:0] din, input logic rd);
        fWr  = wr;
        fDin = din;
        fRd  = rd;
        tick();
        fWr  = 1'b0;
        fRd  = 1'b0;
    endtask

    initial begin
        sRst = 1'b1; sWr = 1'b1; sDin = 8'h55; sRd = 1'b0; sClr = 1'b0;
        fRst = 1'b1; fWr = 1'b1; fDin = 8'h55; fRd = 1'b0; fClr = 1'b0;
        @(negedge clk);
        tick();
        tick();

        checkOutput("rst count", 32'(sCnt), 0);
        checkOutput("rst empty", 32'(sEmpty), 1);
        checkOutput("rst full", 32'(sFull), 0);
        checkOutput("rst almost_empty", 32'(sAe), 1);
        checkOutput("rst almost_full", 32'(sAf), 0);
        checkOutput("rst rd_valid", 32'(sRv), 0);
        checkOutput("rst data_out", 32'(sDout), 0);
        checkOutput("rst overflow", 32'(sOvf), 0);
        checkOutput("rst underflow", 32'(sUnf), 0);
        checkOutput("fwft rst empty", 32'(fEmpty), 1);
        checkOutput("fwft rst rd_valid", 32'(fRv), 0);
        checkOutput("fwft rst count", 32'(fCnt), 0);

        sRst = 1'b0; sWr = 1'b0;
        fRst = 1'b0; fWr = 1'b0;

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("read empty underflow", 32'(sUnf), 1);
        checkOutput("read empty count", 32'(sCnt), 0);
        checkOutput("read empty rd_valid", 32'(sRv), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr underflow", 32'(sUnf), 0);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("fill count", 32'(sCnt), 32'(i + 1));
            checkOutput("fill almost_full", 32'(sAf), 32'((i + 1) >= 30));
            checkOutput("fill almost_empty", 32'(sAe), 32'((i + 1) <= 2));
            checkOutput("fill full", 32'(sFull), 32'((i + 1) == 32));
            checkOutput("fill empty", 32'(sEmpty), 0);
        end

        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        checkOutput("overflow flag", 32'(sOvf), 1);
        checkOutput("overflow count", 32'(sCnt), 32);
        checkOutput("overflow full", 32'(sFull), 1);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain data", 32'(sDout), 32'(i));
            checkOutput("drain rd_valid", 32'(sRv), 1);
            checkOutput("drain count", 32'(sCnt), 32'(31 - i));
        end
        checkOutput("drain empty", 32'(sEmpty), 1);
        checkOutput("drain full", 32'(sFull), 0);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("idle rd_valid", 32'(sRv), 0);
        checkOutput("idle data hold", 32'(sDout), 32'h1F);
        checkOutput("overflow sticky", 32'(sOvf), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr overflow", 32'(sOvf), 0);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        checkOutput("refill full", 32'(sFull), 1);
        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);
        checkOutput("full rw count", 32'(sCnt), 31);
        checkOutput("full rw overflow", 32'(sOvf), 1);
        checkOutput("full rw data", 32'(sDout), 32'h40);
        checkOutput("full rw full", 32'(sFull), 0);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("full rw drain data", 32'(sDout), 32'(8'h40 + i));
        end
        checkOutput("full rw drained", 32'(sEmpty), 1);

        applyStimulus(1'b1, 8'hC3, 1'b1, 1'b1);
        checkOutput("empty rw count", 32'(sCnt), 1);
        checkOutput("empty rw underflow wins clr", 32'(sUnf), 1);
        checkOutput("empty rw overflow cleared", 32'(sOvf), 0);
        checkOutput("empty rw rd_valid", 32'(sRv), 0);
        checkOutput("empty rw empty", 32'(sEmpty), 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("empty rw readback", 32'(sDout), 32'hC3);
        checkOutput("empty rw readback valid", 32'(sRv), 1);
        checkOutput("empty rw count after", 32'(sCnt), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr underflow 2", 32'(sUnf), 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        end
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b1, 8'(k + 5), 1'b1, 1'b0);
            checkOutput("wrap count", 32'(sCnt), 5);
            checkOutput("wrap data", 32'(sDout), 32'(k));
        end
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("wrap tail data", 32'(sDout), 32'(100 + j));
        end
        checkOutput("wrap empty", 32'(sEmpty), 1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pre-reset data", 32'(sDout), 32'hE0);
        sRst = 1'b1;
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        sRst = 1'b0;
        checkOutput("midrst count", 32'(sCnt), 0);
        checkOutput("midrst empty", 32'(sEmpty), 1);
        checkOutput("midrst almost_empty", 32'(sAe), 1);
        checkOutput("midrst rd_valid", 32'(sRv), 0);
        checkOutput("midrst data_out", 32'(sDout), 0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post-reset data", 32'(sDout), 32'h5A);
        checkOutput("post-reset count", 32'(sCnt), 0);

        applyFwftStimulus(1'b1, 8'h11, 1'b0);
        checkOutput("fwft head", 32'(fDout), 32'h11);
        checkOutput("fwft rd_valid", 32'(fRv), 1);
        checkOutput("fwft count 1", 32'(fCnt), 1);
        applyFwftStimulus(1'b1, 8'h22, 1'b0);
        checkOutput("fwft almost_full at 2", 32'(fAf), 1);
        applyFwftStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("fwft almost_empty at 3", 32'(fAe), 0);
        applyFwftStimulus(1'b1, 8'h44, 1'b0);
        checkOutput("fwft full", 32'(fFull), 1);
        applyFwftStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("fwft overflow", 32'(fOvf), 1);
        checkOutput("fwft head kept", 32'(fDout), 32'h11);
        applyFwftStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("fwft pop 1", 32'(fDout), 32'h22);
        checkOutput("fwft pop count", 32'(fCnt), 3);
        applyFwftStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("fwft pop 2", 32'(fDout), 32'h33);
        applyFwftStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("fwft pop 3", 32'(fDout), 32'h44);
        applyFwftStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("fwft drained empty", 32'(fEmpty), 1);
        checkOutput("fwft drained rd_valid", 32'(fRv), 0);
        checkOutput("fwft underflow clear", 32'(fUnf), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
